// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared LC-3 datapath widths, select/ALUK encodings and NZP helpers
package lc3_pkg;

  localparam int DATA_W   = 16;
  localparam int REG_AW   = 3;
  localparam int NUM_REGS = 1 << REG_AW;

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_MEM  = 2'd1;
  localparam logic [1:0] SEL_PC   = 2'd2;
  localparam logic [1:0] SEL_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ALUK_ADD   = 2'd0,
    ALUK_AND   = 2'd1,
    ALUK_NOT   = 2'd2,
    ALUK_PASSA = 2'd3
  } aluk_e;

  localparam logic [2:0] NZP_RESET = 3'b010;

  // Exactly one bit is set for any input value.
  function automatic logic [2:0] nzp_of(input logic [DATA_W-1:0] d);
    if (d == '0)            return 3'b010;
    else if (d[DATA_W-1])   return 3'b100;
    else                    return 3'b001;
  endfunction

endpackage

// File: rtl/lc3_regfile.sv
// rtl/lc3_regfile.sv - 8x16 register file, two async read ports, one sync write port
module lc3_regfile
  import lc3_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/lc3_writeback_stage.sv
// rtl/lc3_writeback_stage.sv - LC-3 writeback: result latch, register file commit, NZP, bypassed reads
module lc3_writeback_stage
  import lc3_pkg::*;
#(
  parameter int DATA_W = lc3_pkg::DATA_W,
  parameter int REG_AW = lc3_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [REG_AW-1:0] in_dr,
  input  logic [1:0]        in_data_sel,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_mem,
  input  logic [DATA_W-1:0] in_pc,
  input  logic              in_ld_reg,
  input  logic              in_ld_cc,
  input  logic              flush,
  input  logic [REG_AW-1:0] sr1,
  input  logic [REG_AW-1:0] sr2,
  output logic [DATA_W-1:0] sr1_data,
  output logic [DATA_W-1:0] sr2_data,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_dr,
  output logic [DATA_W-1:0] wb_data,
  output logic              n,
  output logic              z,
  output logic              p,
  output logic              sel_err
);

  logic              capture;
  logic [DATA_W-1:0] cap_data;
  logic              wb_ld_reg;
  logic              wb_ld_cc;
  logic [2:0]        nzp;
  logic              rf_we;
  logic [DATA_W-1:0] rf_rdata1;
  logic [DATA_W-1:0] rf_rdata2;

  assign capture = in_valid && !flush;

  always_comb begin
    cap_data = '0;
    case (in_data_sel)
      SEL_ALU: cap_data = in_alu;
      SEL_MEM: cap_data = in_mem;
      SEL_PC:  cap_data = in_pc;
      default: cap_data = '0;
    endcase
  end

  // Capture of the new entry and commit of the latched one share the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid  <= 1'b0;
      wb_dr     <= '0;
      wb_data   <= '0;
      wb_ld_reg <= 1'b0;
      wb_ld_cc  <= 1'b0;
      nzp       <= NZP_RESET;
      sel_err   <= 1'b0;
    end else begin
      wb_valid <= capture;
      if (capture) begin
        wb_dr     <= in_dr;
        wb_data   <= cap_data;
        wb_ld_reg <= in_ld_reg;
        wb_ld_cc  <= in_ld_cc;
        if (in_data_sel == SEL_RSVD) sel_err <= 1'b1;
      end
      if (wb_valid && wb_ld_cc) nzp <= nzp_of(wb_data);
    end
  end

  assign rf_we = wb_valid && wb_ld_reg;

  lc3_regfile u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (rf_we),
    .waddr  (wb_dr),
    .wdata  (wb_data),
    .raddr1 (sr1),
    .rdata1 (rf_rdata1),
    .raddr2 (sr2),
    .rdata2 (rf_rdata2)
  );

  assign sr1_data = (rf_we && wb_dr == sr1) ? wb_data : rf_rdata1;
  assign sr2_data = (rf_we && wb_dr == sr2) ? wb_data : rf_rdata2;

  assign n = nzp[2];
  assign z = nzp[1];
  assign p = nzp[0];

endmodule

// File: tb/tb_lc3_writeback_stage.sv
// tb/tb_lc3_writeback_stage.sv - randomized self-checking bench for lc3_writeback_stage
module tb_lc3_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  in_dr;
  logic [1:0]  in_data_sel;
  logic [15:0] in_alu, in_mem, in_pc;
  logic        in_ld_reg, in_ld_cc, flush;
  logic [2:0]  sr1, sr2;
  logic [15:0] sr1_data, sr2_data;
  logic        wb_valid;
  logic [2:0]  wb_dr;
  logic [15:0] wb_data;
  logic        n, z, p, sel_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural registers plus the one in-flight result.
  logic [15:0] m_regs [8];
  logic        m_valid;
  logic [2:0]  m_dr;
  logic [15:0] m_data;
  logic        m_ldreg, m_ldcc;
  logic [2:0]  m_nzp;
  logic        m_selerr;

  always #5 clk = ~clk;

  lc3_writeback_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_dr       (in_dr),
    .in_data_sel (in_data_sel),
    .in_alu      (in_alu),
    .in_mem      (in_mem),
    .in_pc       (in_pc),
    .in_ld_reg   (in_ld_reg),
    .in_ld_cc    (in_ld_cc),
    .flush       (flush),
    .sr1         (sr1),
    .sr2         (sr2),
    .sr1_data    (sr1_data),
    .sr2_data    (sr2_data),
    .wb_valid    (wb_valid),
    .wb_dr       (wb_dr),
    .wb_data     (wb_data),
    .n           (n),
    .z           (z),
    .p           (p),
    .sel_err     (sel_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    m_valid = 0; m_dr = 0; m_data = 0; m_ldreg = 0; m_ldcc = 0;
    m_nzp = 3'b010; m_selerr = 0;
  endtask

  function automatic logic [15:0] exp_rd(input logic [2:0] a);
    if (m_valid && m_ldreg && m_dr == a) return m_data;
    return m_regs[a];
  endfunction

  task automatic rd(input logic [2:0] a, input logic [2:0] b);
    sr1 = a; sr2 = b;
    #1;
    check($sformatf("sr1[%0d]", a), {16'h0, sr1_data}, {16'h0, exp_rd(a)});
    check($sformatf("sr2[%0d]", b), {16'h0, sr2_data}, {16'h0, exp_rd(b)});
  endtask

  task automatic check_state();
    check("wb_valid", {31'h0, wb_valid}, {31'h0, m_valid});
    if (m_valid) begin
      check("wb_dr", {29'h0, wb_dr}, {29'h0, m_dr});
      check("wb_data", {16'h0, wb_data}, {16'h0, m_data});
    end
    check("nzp", {29'h0, n, z, p}, {29'h0, m_nzp});
    check("nzp_onehot", $countones({n, z, p}), 1);
    check("sel_err", {31'h0, sel_err}, {31'h0, m_selerr});
  endtask

  task automatic step(input logic v, input logic fl, input logic [2:0] dr, input logic [1:0] sel,
                      input logic [15:0] alu, input logic [15:0] mem, input logic [15:0] pc,
                      input logic ldreg, input logic ldcc);
    @(negedge clk);
    in_valid = v; flush = fl; in_dr = dr; in_data_sel = sel;
    in_alu = alu; in_mem = mem; in_pc = pc; in_ld_reg = ldreg; in_ld_cc = ldcc;
    @(posedge clk);
    if (m_valid) begin
      if (m_ldreg) m_regs[m_dr] = m_data;
      if (m_ldcc) m_nzp = (m_data == 0) ? 3'b010 : (m_data[15] ? 3'b100 : 3'b001);
    end
    if (v && !fl) begin
      m_valid = 1; m_dr = dr; m_ldreg = ldreg; m_ldcc = ldcc;
      case (sel)
        2'd0: m_data = alu;
        2'd1: m_data = mem;
        2'd2: m_data = pc;
        default: begin m_data = 16'h0000; m_selerr = 1; end
      endcase
    end else begin
      m_valid = 0;
    end
    #1;
    check_state();
    rd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 0; in_valid = 0; flush = 0; in_dr = 0; in_data_sel = 0;
    in_alu = 0; in_mem = 0; in_pc = 0; in_ld_reg = 0; in_ld_cc = 0; sr1 = 0; sr2 = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_state();
    for (int i = 0; i < 8; i++) rd(3'(i), 3'(7 - i));
    check("rst_wb_valid", {31'h0, wb_valid}, 0);
    check("rst_nzp", {29'h0, n, z, p}, 32'h2);
    rst_n = 1;

    // ALU result: bypass next cycle, NZP after the second edge
    step(1, 0, 3, 2'd0, 16'h8001, 16'h0, 16'h0, 1, 1);
    rd(3, 0);
    check("byp_r3", {16'h0, sr1_data}, 32'h8001);
    check("nzp_before_commit", {29'h0, n, z, p}, 32'h2);
    idle();
    rd(3, 3);
    check("r3_commit", {16'h0, sr1_data}, 32'h8001);
    check("nzp_neg", {29'h0, n, z, p}, 32'h4);

    // back-to-back writes to R5
    step(1, 0, 5, 2'd1, 16'hffff, 16'h0000, 16'hffff, 1, 1);
    step(1, 0, 5, 2'd2, 16'h0, 16'h0, 16'h3002, 1, 1);
    rd(5, 5);
    check("byp_r5_newer", {16'h0, sr1_data}, 32'h3002);
    check("nzp_zero", {29'h0, n, z, p}, 32'h2);
    idle();
    rd(5, 1);
    check("r5_final", {16'h0, sr1_data}, 32'h3002);
    check("nzp_pos", {29'h0, n, z, p}, 32'h1);

    // flush kills only the incoming entry
    step(1, 0, 4, 2'd0, 16'h8aaa, 16'h0, 16'h0, 1, 1);
    step(1, 1, 2, 2'd0, 16'h1234, 16'h0, 16'h0, 1, 1);
    check("flush_wb_valid", {31'h0, wb_valid}, 0);
    rd(4, 2);
    check("r4_commit", {16'h0, sr1_data}, 32'h8aaa);
    check("r2_unchanged", {16'h0, sr2_data}, 32'h0);
    idle();
    check("nzp_after_flush", {29'h0, n, z, p}, 32'h4);
    step(0, 1, 6, 2'd0, 16'h5555, 16'h0, 16'h0, 1, 1);

    // reserved select
    step(1, 0, 1, 2'd3, 16'hffff, 16'hffff, 16'hffff, 1, 0);
    check("rsvd_data", {16'h0, wb_data}, 32'h0);
    check("sel_err_set", {31'h0, sel_err}, 1);
    idle();
    rd(1, 1);
    check("r1_zero", {16'h0, sr1_data}, 32'h0);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 2)),
           ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom),
           ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom),
           16'($urandom), 1'($urandom), 1'($urandom));
    end
    check("sel_err_sticky", {31'h0, sel_err}, 1);

    // async reset while an entry is latched
    step(1, 0, 6, 2'd0, 16'h7777, 16'h0, 16'h0, 1, 1);
    check("pre_rst_valid", {31'h0, wb_valid}, 1);
    in_valid = 0; flush = 0; in_ld_reg = 0; in_ld_cc = 0;
    #1 rst_n = 0;
    #1;
    model_reset();
    check_state();
    check("async_rst_valid", {31'h0, wb_valid}, 0);
    rd(6, 0);
    @(negedge clk);
    rst_n = 1;
    idle();
    rd(6, 6);
    check("no_commit_after_rst", {16'h0, sr1_data}, 32'h0);
    check("nzp_after_rst", {29'h0, n, z, p}, 32'h2);
    check("sel_err_cleared", {31'h0, sel_err}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

endmodule
